// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Unsigned 16x16 shift-and-add multiplier that borrows the shared 16-bit
// LEGv8 ALU rather than instantiating its own multiplier.
//
// Each iteration takes three cycles:
//   ADD : acc + mcand. The sum is kept only when mplier[0] is set.
//   SHL : mcand << 1.
//   SHR : mplier >> 1.
// The ALU result is captured at the end of the same cycle that drives it.
//
// The block returns the low 16 bits of the product. It also returns a sticky
// overflow flag, which is set when the full product does not fit in 16 bits.
//
// Optional feature (macro MUL_EARLY_TERM_EN):
//   The block stops as soon as the shifted multiplier becomes zero. A zero
//   multiplier goes straight to DONE. Without the macro, every operation runs
//   all 16 iterations.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   in_a, in_b            multiplicand, multiplier
//   out_valid/out_ready   result handshake (result held until accepted)
//   product, ovf          low 16 bits of a*b, sticky overflow
//   alu_a, alu_b, alu_fs, alu_c0   ALU drive (idle = zero function)
//   alu_f, alu_status     ALU result and {V,C,N,Z}; only C is used
// -----------------------------------------------------------------------------
module alu_mul_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] product,
   output logic        ovf,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_fs,
   output logic        alu_c0,
   input  logic [15:0] alu_f,
   input  logic [3:0]  alu_status
);

   localparam logic [4:0] FS_ADD  = 5'b01000;
   localparam logic [4:0] FS_SHL  = 5'b10000;
   localparam logic [4:0] FS_SHR  = 5'b10100;
   localparam logic [4:0] FS_ZERO = 5'b11000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_SHL,
      S_SHR,
      S_DONE
   } state_t;

   state_t      state_reg;
   logic [15:0] acc_reg;
   logic [15:0] mcand_reg;
   logic [15:0] mplier_reg;
   logic [3:0]  iter_reg;
   logic        ovf_reg;
   logic        in_ready_reg;
   logic        out_valid_reg;
   logic [15:0] product_reg;
   logic [15:0] alu_a_reg;
   logic [15:0] alu_b_reg;
   logic [4:0]  alu_fs_reg;

   // skip_all: the operation can finish without any iterations.
   // stop_early: the multiplier shifted out this cycle leaves nothing to add.
   logic skip_all;
   logic stop_early;
   logic last_iter;

`ifdef MUL_EARLY_TERM_EN
   assign skip_all   = (in_b == 16'd0);
   assign stop_early = (alu_f == 16'd0);
`else
   assign skip_all   = 1'b0;
   assign stop_early = 1'b0;
`endif

   assign last_iter = (iter_reg == 4'd15) || stop_early;

   // Every ALU drive register is loaded on the edge that enters the state
   // using it. That way, the ALU sees the correct operands during the whole
   // state. Where a register changes on that same edge, the new value is
   // forwarded: for example, the first ADD takes its multiplicand from in_a.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         acc_reg       <= 16'd0;
         mcand_reg     <= 16'd0;
         mplier_reg    <= 16'd0;
         iter_reg      <= 4'd0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         product_reg   <= 16'd0;
         alu_a_reg     <= 16'd0;
         alu_b_reg     <= 16'd0;
         alu_fs_reg    <= FS_ZERO;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  acc_reg      <= 16'd0;
                  mcand_reg    <= in_a;
                  mplier_reg   <= in_b;
                  ovf_reg      <= 1'b0;
                  iter_reg     <= 4'd0;
                  in_ready_reg <= 1'b0;
                  if (skip_all) begin
                     state_reg     <= S_DONE;
                     out_valid_reg <= 1'b1;
                     product_reg   <= 16'd0;
                  end else begin
                     state_reg  <= S_ADD;
                     alu_a_reg  <= 16'd0;
                     alu_b_reg  <= in_a;
                     alu_fs_reg <= FS_ADD;
                  end
               end
            end

            S_ADD: begin
               if (mplier_reg[0]) begin
                  acc_reg <= alu_f;
                  ovf_reg <= ovf_reg | alu_status[2];
               end
               state_reg  <= S_SHL;
               alu_a_reg  <= mcand_reg;
               alu_b_reg  <= 16'd1;
               alu_fs_reg <= FS_SHL;
            end

            S_SHL: begin
               mcand_reg <= alu_f;
               // Bit 15 of mcand is about to be shifted out. If any higher
               // multiplier bit is still pending, a later partial product
               // would need that lost bit, so the result cannot fit.
               if (mcand_reg[15] && (mplier_reg[15:1] != 15'd0)) begin
                  ovf_reg <= 1'b1;
               end
               state_reg  <= S_SHR;
               alu_a_reg  <= mplier_reg;
               alu_b_reg  <= 16'd1;
               alu_fs_reg <= FS_SHR;
            end

            S_SHR: begin
               mplier_reg <= alu_f;
               iter_reg   <= iter_reg + 4'd1;
               if (last_iter) begin
                  state_reg     <= S_DONE;
                  out_valid_reg <= 1'b1;
                  product_reg   <= acc_reg;
                  alu_a_reg     <= 16'd0;
                  alu_b_reg     <= 16'd0;
                  alu_fs_reg    <= FS_ZERO;
               end else begin
                  state_reg  <= S_ADD;
                  alu_a_reg  <= acc_reg;
                  alu_b_reg  <= mcand_reg;
                  alu_fs_reg <= FS_ADD;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  state_reg     <= S_IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end

            default: begin
               state_reg     <= S_IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               alu_a_reg     <= 16'd0;
               alu_b_reg     <= 16'd0;
               alu_fs_reg    <= FS_ZERO;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign product   = product_reg;
   assign ovf       = ovf_reg;
   assign alu_a     = alu_a_reg;
   assign alu_b     = alu_b_reg;
   assign alu_fs    = alu_fs_reg;
   assign alu_c0    = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Self-checking bench for alu_mul_sequencer.
//
// A behavioural LEGv8 ALU sits beside the DUT. Expected results come from
// plain 32-bit arithmetic on the operands:
//   - product = (a*b) mod 2^16
//   - ovf     = (a*b) > 16'hFFFF
//   - latency = 3*N+1, where N = 16, or the multiplier bit length when
//     MUL_EARLY_TERM_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        ovf;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [4:0]  alu_fs;
   logic        alu_c0;
   logic [15:0] alu_f;
   logic [3:0]  alu_status;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   alu_mul_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .product    (product),
      .ovf        (ovf),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_fs     (alu_fs),
      .alu_c0     (alu_c0),
      .alu_f      (alu_f),
      .alu_status (alu_status)
   );

   // Behavioural shared ALU. FS[4:2] selects the operation:
   //   AND, OR, ADD, XOR, SHL, SHR, zero.
   logic [15:0] xa, xb;
   logic [16:0] sum;
   logic        c_flag, v_flag;

   always_comb begin
      xa     = alu_fs[1] ? ~alu_a : alu_a;
      xb     = alu_fs[0] ? ~alu_b : alu_b;
      sum    = {1'b0, xa} + {1'b0, xb} + {16'd0, alu_c0};
      alu_f  = 16'd0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (alu_fs[4:2])
         3'd0: alu_f = xa & xb;
         3'd1: alu_f = xa | xb;
         3'd2: begin
            alu_f  = sum[15:0];
            c_flag = sum[16];
            v_flag = (xa[15] == xb[15]) && (sum[15] != xa[15]);
         end
         3'd3: alu_f = xa ^ xb;
         3'd4: alu_f = xa << xb[3:0];
         3'd5: alu_f = xa >> xb[3:0];
         default: alu_f = 16'd0;
      endcase
      alu_status = {v_flag, c_flag, alu_f[15], (alu_f == 16'd0)};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_latency(input logic [15:0] b);
      int n;
`ifdef MUL_EARLY_TERM_EN
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) n = i + 1;
      end
`else
      n = 16;
`endif
      return 3 * n + 1;
   endfunction

   // One complete operation: accept, wait for the result, hold it for
   // 'hold' cycles with out_ready low, then release it.
   // With alu_chk set, the ALU function is also checked on every busy cycle.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input int hold, input bit alu_chk);
      logic [31:0] full;
      logic [15:0] p_seen;
      logic        o_seen;
      int          cyc;
      logic [4:0]  fs_exp;

      full = {16'd0, a} * {16'd0, b};
      @(negedge clock);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 200) begin
         if (alu_chk) begin
            case ((cyc - 1) % 3)
               0:       fs_exp = 5'b01000;
               1:       fs_exp = 5'b10000;
               default: fs_exp = 5'b10100;
            endcase
            chk("alu_fs", {27'd0, alu_fs}, {27'd0, fs_exp});
            if (fs_exp != 5'b01000) chk("alu_b_shift", {16'd0, alu_b}, 32'd1);
         end
         @(negedge clock);
         cyc++;
      end
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("latency", cyc, exp_latency(b));
      chk("product", {16'd0, product}, {16'd0, full[15:0]});
      chk("ovf", {31'd0, ovf}, {31'd0, (full > 32'h0000_FFFF)});
      p_seen = product;
      o_seen = ovf;

      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         in_a     = 16'hDEAD;
         in_b     = 16'hBEEF;
         @(negedge clock);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_prod", {16'd0, product}, {16'd0, p_seen});
         chk("hold_ovf", {31'd0, ovf}, {31'd0, o_seen});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk("release_ready", {31'd0, in_ready}, 32'd1);
      chk("release_valid", {31'd0, out_valid}, 32'd0);
      $display("op a=0x%04h b=0x%04h product=0x%04h ovf=%0b latency=%0d",
               a, b, p_seen, o_seen, cyc);
   endtask

   initial begin
      logic [15:0] ra, rb;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 16'd0;
      in_b      = 16'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_product", {16'd0, product}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_fs", {27'd0, alu_fs}, 32'h18);
      chk("rst_alu_a", {16'd0, alu_a}, 32'd0);

      // Directed cases.
      run_op(16'd3, 16'd5, 20, 1'b1);
      run_op(16'd3, 16'd0, 2, 1'b0);
      run_op(16'h0100, 16'h0100, 0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 0, 1'b0);
      run_op(16'h8000, 16'h0003, 1, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);

      // Reset in the middle of an operation drops it without a result.
      @(negedge clock);
      in_a     = 16'd9;
      in_b     = 16'd11;
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (6) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_fs", {27'd0, alu_fs}, 32'h18);
      $display("reset mid-operation in_ready=%0b out_valid=%0b fs=%05b",
               in_ready, out_valid, alu_fs);
      run_op(16'd7, 16'd6, 0, 1'b0);

      // Randomised operands. The operand widths are masked at random so
      // that both fitting and overflowing products are exercised.
      for (int k = 0; k < 24; k++) begin
         ra = 16'($urandom) & (16'hFFFF >> $urandom_range(0, 15));
         rb = 16'($urandom) & (16'hFFFF >> $urandom_range(0, 15));
         run_op(ra, rb, $urandom_range(0, 3), (k % 6) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle unsigned 16×16 multiply controller that reuses the shared 16-bit LEGv8 ALU (AND/OR/ADD/XOR/SHL/SHR) instead of a dedicated multiplier array. It accepts an operand pair over a valid/ready handshake and issues one ALU operation per cycle (add, shift-left, shift-right) to run a shift-and-add algorithm. It registers the ALU result back into its internal accumulator and operand registers. It returns the low 16 bits of the product plus a sticky overflow flag over an output valid/ready handshake. It sits beside the ALU in the datapath and owns the ALU's FS/A/B/C0 inputs while busy.

## Interface
- No parameters. Width is fixed at 16 to match the ALU.
- clock  input  1  rising-edge clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept; high only in IDLE
- in_a  input  16  multiplicand
- in_b  input  16  multiplier
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- product  output  16  low 16 bits of a×b
- ovf  output  1  product did not fit in 16 bits
- alu_a, alu_b  output  16  ALU operand drive
- alu_fs  output  5  ALU function select (FS[4:2] op, FS[1] A-invert, FS[0] B-invert)
- alu_c0  output  1  ALU carry-in
- alu_f  input  16  ALU result
- alu_status  input  4  ALU status {V,C,N,Z}; the block uses bit 2 (C)

## Operation
- Registers: acc[15:0], mcand[15:0], mplier[15:0], ovf (sticky), state.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: acc←0, mcand←in_a, mplier←in_b, ovf←0, then go to ADD.
  - With the macro defined and in_b==0, go directly to DONE instead.
- ADD:
  - Drives alu_fs=5'b01000 (ADD, no invert), alu_a=acc, alu_b=mcand, alu_c0=0.
  - If mplier[0]=1: acc←alu_f, and ovf←ovf|alu_status[2].
  - If mplier[0]=0: acc is unchanged.
  - Next state is SHL.
- SHL:
  - Drives alu_fs=5'b10000, alu_a=mcand, alu_b=16'd1, alu_c0=0; mcand←alu_f.
  - If mcand[15]=1 and mplier[15:1]≠0: ovf←1.
  - Next state is SHR.
- SHR:
  - Drives alu_fs=5'b10100, alu_a=mplier, alu_b=16'd1, alu_c0=0; mplier←alu_f.
  - Increments the iteration counter (0..15).
  - Goes to DONE after the 16th iteration, or earlier per Configuration; otherwise to ADD.
- DONE:
  - out_valid=1, product=acc.
  - On out_ready, go to IDLE.
- In IDLE and DONE the ALU drive is idle: alu_fs=5'b11000 (zero output), alu_a=alu_b=0, alu_c0=0.
- The ALU path is purely combinational. ALU outputs are sampled at the end of the same cycle in which the ALU is driven.
- Arithmetic: unsigned; all bits above bit 15 are discarded. ovf=1 exactly when the true 32-bit product exceeds 16'hFFFF.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, ovf=0, acc=mcand=mplier=0, ALU drive idle.
- Let accept edge T be the edge where in_valid & in_ready.
- An iteration is exactly 3 cycles (ADD, SHL, SHR).
- out_valid rises 3·N+1 cycles after T, where N is the number of iterations executed.
- out_valid, product and ovf are stable until the out_ready edge. The block returns to IDLE on the next cycle and in_ready=1 then.
- There is no same-cycle DONE→accept; back-to-back throughput is at least one cycle of IDLE between operations.
- in_valid while busy is ignored: in_ready=0 and operands are not sampled.
- Reset asserted in any state: on the next edge all registers take their reset values and the in-flight operation is dropped with no output.

## Configuration
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - After SHR, if the new mplier==0, go to DONE.
  - An accept with in_b==0 goes straight to DONE.
  - N = (index of highest set bit of in_b)+1, or 0 when in_b==0.
- Undefined: N=16 always, so latency is 49 cycles regardless of operands.

## Test plan
- a=3, b=5, out_ready=1, macro undefined → product=0x000F, ovf=0, out_valid 49 cycles after accept.
- Same operands with MUL_EARLY_TERM_EN → product=0x000F, ovf=0, out_valid 10 cycles after accept; b=0 → product=0, out_valid 1 cycle after accept.
- a=0x0100, b=0x0100 → product=0x0000, ovf=1; a=0xFFFF, b=0x0001 → product=0xFFFF, ovf=0; a=0x8000, b=0x0003 → product=0x8000, ovf=1.
- Hold out_ready=0 for 20 cycles in DONE → out_valid, product and ovf are constant and in_ready=0; in_valid pulses are ignored. Release → IDLE next cycle.
- Assert reset during cycle 7 of an operation → next cycle state is IDLE, in_ready=1, out_valid=0, ALU drive idle (fs=5'b11000). A following a=7, b=6 yields 0x002A.
- Per-cycle ALU check during a=3, b=5: the fs sequence is 01000/10000/10100 repeating, with alu_b=1 on every shift cycle.
